// File: rtl/demux_dispatch_ctrl.sv
// One-entry dispatch sequencer for a 1-to-4 demux: fixed-channel or round-robin targeting.
// Optional per-channel fire counters when DEMUX_DISPATCH_STATS_EN is defined.
module demux_dispatch_ctrl #(
  parameter int DW      = 8,
  parameter int CH_BITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  input  logic               cfg_mode,
  input  logic [CH_BITS-1:0] cfg_sel,
  input  logic [3:0]         cfg_en,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [DW-1:0]      out_data,
  output logic [CH_BITS-1:0] sel,
  output logic               busy
`ifdef DEMUX_DISPATCH_STATS_EN
  ,
  input  logic               cnt_clr,
  output logic [63:0]        cnt_o
`endif
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CH_BITS-1:0] rr_ptr;
  logic [CH_BITS-1:0] target;
  logic               target_ok;
  logic               capture;
  logic               fire;

  // First enabled channel at or after ptr, wrapping modulo 4.
  function automatic logic [CH_BITS-1:0] rr_pick(input logic [CH_BITS-1:0] ptr,
                                                 input logic [3:0] en);
    logic [CH_BITS-1:0] idx;
    rr_pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + CH_BITS'(k);
      if (en[idx]) rr_pick = idx;
    end
  endfunction

  assign busy      = (state_q == HOLD);
  assign target    = cfg_mode ? rr_pick(rr_ptr, cfg_en) : cfg_sel;
  assign target_ok = cfg_mode ? (|cfg_en) : 1'b1;
  assign fire      = busy && out_ready[sel];
  assign in_ready  = target_ok && (!busy || fire);
  assign capture   = in_valid && in_ready;
  assign out_valid = busy ? (4'(1) << sel) : 4'b0000;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (capture) state_d = HOLD;
      HOLD: begin
        // A fire that coincides with a capture keeps the buffer full.
        if (capture)   state_d = HOLD;
        else if (fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      out_data <= '0;
      sel      <= '0;
      rr_ptr   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        out_data <= in_data;
        sel      <= target;
        if (cfg_mode) rr_ptr <= target + CH_BITS'(1);
      end
    end
  end

`ifdef DEMUX_DISPATCH_STATS_EN
  logic [15:0] cnt [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (fire) begin
      cnt[sel] <= cnt[sel] + 16'd1;
    end
  end

  assign cnt_o = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Bench for demux_dispatch_ctrl: directed scenarios plus randomized traffic against a word-level model.
module tb_demux_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       cfg_mode;
  logic [1:0] cfg_sel;
  logic [3:0] cfg_en;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic [1:0] sel;
  logic       busy;
`ifdef DEMUX_DISPATCH_STATS_EN
  logic        cnt_clr;
  logic [63:0] cnt_o;
`endif

  demux_dispatch_ctrl #(.DW(8), .CH_BITS(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_mode(cfg_mode), .cfg_sel(cfg_sel), .cfg_en(cfg_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .sel(sel), .busy(busy)
`ifdef DEMUX_DISPATCH_STATS_EN
    , .cnt_clr(cnt_clr), .cnt_o(cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: one held word, its channel, and the round-robin start point.
  bit         m_busy;
  int         m_ptr;
  int         m_sel;
  logic [7:0] m_data;
  int         m_cnt [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_target();
    if (!cfg_mode) return int'(cfg_sel);
    for (int k = 0; k < 4; k++)
      if (cfg_en[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  function automatic bit exp_ready();
    bit ok;
    ok = cfg_mode ? (cfg_en != 4'b0000) : 1'b1;
    return ok && (!m_busy || out_ready[m_sel]);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_sel = 0; m_data = 8'h00;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // Check outputs mid-cycle, then advance one clock and update the model. Starts and ends at negedge.
  task automatic cyc();
    bit cap, fr;
    int tgt;
    #1;
    chk("in_ready", in_ready, exp_ready());
    chk("busy", busy, m_busy);
    chk("out_valid", out_valid, m_busy ? (64'd1 << m_sel) : 64'd0);
    chk("out_data", out_data, m_data);
    chk("sel", sel, m_sel);
`ifdef DEMUX_DISPATCH_STATS_EN
    for (int i = 0; i < 4; i++) chk("cnt", cnt_o[16*i +: 16], m_cnt[i]);
`endif
    fr  = m_busy && out_ready[m_sel];
    cap = in_valid && exp_ready();
    @(posedge clk);
`ifdef DEMUX_DISPATCH_STATS_EN
    if (cnt_clr) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    else if (fr) m_cnt[m_sel] = (m_cnt[m_sel] + 1) % 65536;
`endif
    if (cap) begin
      tgt    = pick_target();
      m_data = in_data;
      m_sel  = tgt;
      m_busy = 1;
      if (cfg_mode) m_ptr = (tgt + 1) % 4;
    end else if (fr) begin
      m_busy = 0;
    end
    @(negedge clk);
  endtask

  // Asynchronous reset raised between edges; outputs must clear without a clock.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sel", sel, 2'b00);
    chk("rst_out_data", out_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int rr_exp [6];
    int mk_exp [4];
    rr_exp = '{0, 1, 2, 3, 0, 1};
    mk_exp = '{1, 3, 1, 3};
    rst = 1'b1; in_valid = 0; in_data = 0; cfg_mode = 0; cfg_sel = 0;
    cfg_en = 4'b1111; out_ready = 4'b0000;
`ifdef DEMUX_DISPATCH_STATS_EN
    cnt_clr = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    do_reset();

    // Fixed mode: stall three cycles, deliver on the fourth.
    cfg_mode = 0; cfg_sel = 2; in_valid = 1; in_data = 8'h3C;
    cyc();
    in_valid = 0; in_data = 8'h77;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) out_ready = 4'b0100;
      #1;
      chk("fix_valid", out_valid, 4'b0100);
      chk("fix_data", out_data, 8'h3C);
      chk("fix_sel", sel, 2'd2);
      chk("fix_ready", in_ready, (i == 3) ? 1'b1 : 1'b0);
      #1 cyc();
    end
    chk("fix_drained", busy, 1'b0);
    out_ready = 4'b0000;

    // Reset while holding 8'hA5.
    cfg_sel = 0; in_valid = 1; in_data = 8'hA5;
    cyc();
    in_valid = 0;
    chk("hold_a5", out_data, 8'hA5);
    do_reset();
    #1 chk("post_rst_ready", in_ready, 1'b1);
    cyc();

    // Round-robin over all channels, back to back.
    cfg_mode = 1; cfg_en = 4'b1111; out_ready = 4'b1111; in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(i + 1);
      #1 chk("rr_ready", in_ready, 1'b1);
      cyc();
      chk("rr_sel", sel, rr_exp[i]);
      chk("rr_data", out_data, 8'(i + 1));
    end
    in_valid = 0;
    cyc();

    // Masked round-robin, then an empty mask stalls upstream.
    do_reset();
    cfg_mode = 1; cfg_en = 4'b1010; out_ready = 4'b1111; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h40 + 8'(i);
      cyc();
      chk("mask_sel", sel, mk_exp[i]);
    end
    cfg_en = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mask_stall", in_ready, 1'b0);
      cyc();
    end
    chk("mask_empty", busy, 1'b0);
    in_valid = 0;

    // Config change while holding does not retarget the held word.
    cfg_mode = 0; cfg_sel = 1; cfg_en = 4'b1111; out_ready = 4'b0000; in_valid = 1; in_data = 8'h55;
    cyc();
    in_valid = 0; cfg_sel = 3; cfg_mode = 1;
    cyc();
    chk("cfg_keep_sel", sel, 2'd1);
    chk("cfg_keep_valid", out_valid, 4'b0010);
    cfg_mode = 0; out_ready = 4'b0010; in_valid = 1; in_data = 8'h66;
    cyc();
    chk("cfg_next_sel", sel, 2'd3);
    chk("cfg_next_data", out_data, 8'h66);
    in_valid = 0; out_ready = 4'b1000;
    cyc();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
      if ($urandom_range(0, 7) == 0) cfg_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) cfg_sel  = 2'($urandom);
      if ($urandom_range(0, 7) == 0) cfg_en   = 4'($urandom);
      cyc();
    end
    in_valid = 0; out_ready = 4'b1111; cfg_mode = 0;
    cyc();

`ifdef DEMUX_DISPATCH_STATS_EN
    do_reset();
    cfg_mode = 0; cfg_sel = 0; out_ready = 4'b1111; in_valid = 1;
    for (int i = 0; i < 5; i++) cyc();
    in_valid = 0;
    cyc();
    chk("cnt_five", cnt_o[15:0], 16'd5);
    cfg_sel = 1; in_valid = 1;
    for (int i = 0; i < 65536; i++) cyc();
    in_valid = 0;
    cyc();
    chk("cnt_wrap", cnt_o[31:16], 16'd0);
    cfg_sel = 2; in_valid = 1;
    cyc();
    in_valid = 0; cnt_clr = 1;
    cyc();
    cnt_clr = 0;
    chk("cnt_clr_fire", cnt_o, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/demux_dispatch_ctrl.md
Name: demux_dispatch_ctrl

Overview:
- Sequencer for the 1-to-4 demultiplexer datapath: accepts one input data stream over a valid/ready handshake and dispatches each word to exactly one of four output channels.
- Holds each word in a one-entry buffer until the chosen channel accepts it.
- Drives the demux select code and the one-hot channel valids.
- Target is either a fixed software-programmed channel or round-robin over an enable mask.

Parameters:
- DW, 8, data word width.
- CH_BITS, 2, select width (fixed; 4 channels). Not intended to be overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept the word this cycle.
- in_data  input  DW  upstream word.
- cfg_mode  input  1  0 = fixed channel, 1 = round-robin.
- cfg_sel  input  2  target channel in fixed mode.
- cfg_en  input  4  channel enable mask used in round-robin mode.
- out_valid  output  4  one-hot valid to channel i; all zero when empty.
- out_ready  input  4  channel i accepts.
- out_data  output  DW  held word, shared by all channels.
- sel  output  2  demux select code for the held word.
- busy  output  1  buffer holds a word.

Behaviour:
- Reset, asynchronous on rst high, regardless of clk:
  - state = IDLE; out_valid = 4'b0000; out_data = 0; sel = 2'b00; rr_ptr = 0; busy = 0.
- States:
  - IDLE: buffer empty.
  - HOLD: buffer full, target latched.
- Firing conditions:
  - capture = in_valid && in_ready.
  - fire = busy && out_ready[sel].
- in_ready = target_ok && (state == IDLE || fire). This is the combinational pass-through of the drain, giving full throughput of one word per cycle.
- target_ok:
  - Fixed mode: always 1.
  - Round-robin mode: |cfg_en. When cfg_en == 0, in_ready = 0 and upstream stalls.
- Target computation, evaluated at capture:
  - Fixed mode: cfg_sel. Enable mask is ignored.
  - Round-robin mode: first i with cfg_en[i] = 1, searching rr_ptr, rr_ptr+1, ... mod 4. On capture, rr_ptr <= target + 1 mod 4 (3 wraps to 0). In fixed mode rr_ptr is unchanged.
- Capture (registered): out_data <= in_data; sel <= target; state <= HOLD.
- Latency: word captured at edge N; out_valid[sel] = 1 and out_data valid from cycle N+1. Minimum one cycle, in to out.
- While in HOLD:
  - out_valid = one-hot(sel); out_data and sel are stable until fire.
  - Config changes do not alter the latched target; they apply from the next capture.
  - out_ready on non-target channels is ignored.
- Transitions:
  - On fire with capture in the same cycle: stay HOLD and load the new word and target.
  - On fire without capture: go to IDLE; out_valid <= 0. out_data keeps its last value.
  - On no fire: stay HOLD.
- Round-robin skips disabled channels. A channel disabled while it holds the latched target still completes that word.
- Reset mid-transfer discards the held word; no out_valid glitch after rst deasserts.
- Exactly one out_valid bit is ever high; none is high in IDLE.

Optional Feature:
- Macro DEMUX_DISPATCH_STATS_EN.
- Defined:
  - Adds output cnt_o (4 x 16 = 64 bits), channel i in bits [16i+15:16i].
  - Each 16-bit counter increments on fire to channel i and wraps 16'hFFFF -> 0.
  - Counters clear on rst.
  - Adds input cnt_clr (1 bit), which synchronously clears all counters. If cnt_clr coincides with a fire, the result is 0.
- Undefined: no counters, no cnt_o or cnt_clr ports; all other behaviour identical.

Test Plan:
- Reset: assert rst mid-HOLD (buffer holding 8'hA5) -> out_valid = 0, busy = 0, sel = 0 immediately, without waiting for a clock edge; after release, in_ready = 1.
- Fixed mode: cfg_sel = 2, send 8'h3C with out_ready = 4'b0000 for 3 cycles, then 4'b0100 -> out_valid = 4'b0100 held 4 cycles, out_data = 8'h3C, sel = 2, in_ready = 0 while stalled.
- Round-robin: cfg_en = 4'b1111, all out_ready = 1, send 8'h01..8'h06 back-to-back -> sel sequence 0,1,2,3,0,1; one word per cycle; in_ready stays 1.
- Masked round-robin: cfg_en = 4'b1010, send 4 words -> sel 1,3,1,3. Then cfg_en = 0 -> in_ready = 0 after the held word drains.
- Config change in HOLD: word latched to ch1, switch cfg_mode/cfg_sel to 3 before out_ready[1] -> word still delivered on ch1; next word goes to ch3.
- With DEMUX_DISPATCH_STATS_EN defined:
  - 5 fires to ch0 -> cnt_o[15:0] = 5.
  - Preload via 65536 fires -> counter wraps to 0.
  - cnt_clr during a fire -> counter reads 0.
